// File: rtl/seq_pkg.sv
// Shared encodings for the serializer and the downstream sequence detector.
package seq_pkg;

   typedef enum logic {
      SER_IDLE  = 1'b0,
      SER_SHIFT = 1'b1
   } ser_state_e;

   // Detector progress through the pattern it matches; DET_S3 is the match state.
   typedef enum logic [1:0] {
      DET_IDLE = 2'd0,
      DET_S1   = 2'd1,
      DET_S2   = 2'd2,
      DET_S3   = 2'd3
   } det_state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         inc_i,
   output logic [W-1:0] count_o
);

   logic [W-1:0] count_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else if (inc_i && (count_q != '1)) begin
         count_q <= count_q + W'(1);
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial stage feeding the sequence detector one bit per clock,
// with zero-gap streaming of back-to-back words and a 0 fill when idle.
module seq_bit_serializer
   import seq_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b1,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] load_data,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             dout,
   output logic             dout_valid,
   output logic             last_bit,
   output logic             busy,
   output logic [CNT_W-1:0] word_cnt
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LastIdx = CW'(WIDTH - 1);

   ser_state_e       state_q;
   logic [WIDTH-1:0] shift_q;
   logic [CW-1:0]    bit_cnt_q;

   logic             on_last;
   logic             handshake;
   logic             head;
   logic [WIDTH-1:0] shifted;

   assign on_last    = (state_q == SER_SHIFT) && (bit_cnt_q == LastIdx);
   // Depends on registered state only, so no load_valid -> load_ready path.
   assign load_ready = (state_q == SER_IDLE) || on_last;
   assign handshake  = load_valid && load_ready;

   assign head    = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
   assign shifted = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= SER_IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
      end else begin
         case (state_q)
            SER_IDLE: begin
               if (handshake) begin
                  state_q   <= SER_SHIFT;
                  shift_q   <= load_data;
                  bit_cnt_q <= '0;
               end
            end
            SER_SHIFT: begin
               if (handshake) begin
                  shift_q   <= load_data;
                  bit_cnt_q <= '0;
               end else if (on_last) begin
                  state_q   <= SER_IDLE;
                  shift_q   <= shifted;
                  bit_cnt_q <= '0;
               end else begin
                  shift_q   <= shifted;
                  bit_cnt_q <= bit_cnt_q + CW'(1);
               end
            end
            default: begin
               state_q   <= SER_IDLE;
               shift_q   <= '0;
               bit_cnt_q <= '0;
            end
         endcase
      end
   end

   assign busy       = (state_q == SER_SHIFT);
   assign dout_valid = (state_q == SER_SHIFT);
   assign dout       = (state_q == SER_SHIFT) && head;
   assign last_bit   = on_last;

   sat_counter #(
      .W(CNT_W)
   ) u_word_cnt (
      .clk_i  (clk),
      .rst_i  (rst),
      .inc_i  (on_last),
      .count_o(word_cnt)
   );

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Two serializers (MSB-first/16-bit count, LSB-first/2-bit count) driven in
// lockstep and compared against an expected-bit-stream model.
module tb_seq_bit_serializer;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] ld;
   logic       lv;

   logic        rdy  [2];
   logic        dout [2];
   logic        dv   [2];
   logic        lb   [2];
   logic        bsy  [2];
   logic [15:0] wc0;
   logic [1:0]  wc1;

   int vectors     = 0;
   int miscompares = 0;

   // Pending output bits per instance, front = bit currently on dout.
   // Encoding: bit0 = data bit, bit1 = final bit of its word.
   int mq      [2][$];
   int cnt     [2];
   int cnt_max [2] = '{65535, 3};

   always #5 clk = ~clk;

   seq_bit_serializer #(
      .WIDTH    (4),
      .MSB_FIRST(1'b1),
      .CNT_W    (16)
   ) u_msb (
      .clk       (clk),
      .rst       (rst),
      .load_data (ld),
      .load_valid(lv),
      .load_ready(rdy[0]),
      .dout      (dout[0]),
      .dout_valid(dv[0]),
      .last_bit  (lb[0]),
      .busy      (bsy[0]),
      .word_cnt  (wc0)
   );

   seq_bit_serializer #(
      .WIDTH    (4),
      .MSB_FIRST(1'b0),
      .CNT_W    (2)
   ) u_lsb (
      .clk       (clk),
      .rst       (rst),
      .load_data (ld),
      .load_valid(lv),
      .load_ready(rdy[1]),
      .dout      (dout[1]),
      .dout_valid(dv[1]),
      .last_bit  (lb[1]),
      .busy      (bsy[1]),
      .word_cnt  (wc1)
   );

   task automatic chk(input string tag, input int i, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, i, obs, exp);
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < 2; i++) begin
         int          sz;
         int          e;
         logic [31:0] wc;
         sz = mq[i].size();
         e  = (sz > 0) ? mq[i][0] : 0;
         wc = (i == 0) ? {16'h0, wc0} : {30'h0, wc1};
         chk("dout",       i, {31'h0, dout[i]}, (sz > 0) ? (e & 1) : 0);
         chk("dout_valid", i, {31'h0, dv[i]},   (sz > 0) ? 1 : 0);
         chk("busy",       i, {31'h0, bsy[i]},  (sz > 0) ? 1 : 0);
         chk("last_bit",   i, {31'h0, lb[i]},   (sz > 0) ? ((e >> 1) & 1) : 0);
         chk("load_ready", i, {31'h0, rdy[i]},  (sz <= 1) ? 1 : 0);
         chk("word_cnt",   i, wc, cnt[i]);
      end
   endtask

   // Effect of one rising edge: retire the shown bit, accept a word if ready.
   task automatic model_edge();
      for (int i = 0; i < 2; i++) begin
         bit hs;
         int e;
         hs = lv && (mq[i].size() <= 1);
         if (mq[i].size() > 0) begin
            e = mq[i].pop_front();
            if (((e >> 1) & 1) == 1 && cnt[i] < cnt_max[i]) cnt[i]++;
         end
         if (hs) begin
            for (int j = 0; j < 4; j++) begin
               int b;
               b = (i == 0) ? ((int'(ld) >> (3 - j)) & 1) : ((int'(ld) >> j) & 1);
               mq[i].push_back(b | ((j == 3) ? 2 : 0));
            end
         end
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         mq[i].delete();
         cnt[i] = 0;
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
   endtask

   // 3 ns reset pulse straddling a rising edge; outputs must clear before it.
   task automatic reset_pulse();
      #3 rst = 1'b1;
      #1 model_reset();
      check_all();
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_all();
   endtask

   initial begin
      rst = 1'b1;
      ld  = 4'h0;
      lv  = 1'b0;
      model_reset();
      #2 check_all();
      @(negedge clk);
      rst = 1'b0;
      check_all();

      // Single word: 1,0,1,1 MSB-first, 1,1,0,1 LSB-first.
      ld = 4'hB; lv = 1'b1;
      cycle();
      lv = 1'b0; ld = 4'h0;
      repeat (5) cycle();

      // Back-to-back B then 6 with load_valid held high.
      ld = 4'hB; lv = 1'b1;
      cycle();
      ld = 4'h6;
      repeat (4) cycle();
      lv = 1'b0; ld = 4'h0;
      repeat (5) cycle();

      // 4'hF pulsed while a word is in flight must be ignored.
      ld = 4'h9; lv = 1'b1;
      cycle();
      ld = 4'hF;
      cycle();
      lv = 1'b0; ld = 4'h0;
      repeat (5) cycle();

      // Reset in the middle of a word, then a clean word.
      ld = 4'hD; lv = 1'b1;
      cycle();
      lv = 1'b0;
      cycle();
      reset_pulse();
      ld = 4'h1; lv = 1'b1;
      cycle();
      lv = 1'b0; ld = 4'h0;
      repeat (5) cycle();

      // Several more words so the 2-bit counter saturates.
      repeat (5) begin
         ld = 4'($urandom);
         lv = 1'b1;
         cycle();
         lv = 1'b0;
         repeat (4) cycle();
      end

      // Random valid/data, including loads offered while not ready.
      repeat (80) begin
         lv = 1'($urandom_range(0, 1));
         ld = 4'($urandom);
         cycle();
      end
      lv = 1'b0;
      repeat (6) cycle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
